// File: rtl/pcs_gen_lane_scheduler.sv
// Run-controller for the multi-lane PCS generator array: arms the masked lanes,
// runs a bounded burst with rotating data-select, drains the pipeline and reports done.
module pcs_gen_lane_scheduler #(
    parameter int N_LANES         = 8,
    parameter int N_PCS_WORDS_OUT = 4,
    parameter int NB_CNT          = 16,
    parameter int NB_HOLD         = 8,
    parameter int DRAIN_CYCLES    = 4
) (
    input  logic                                 clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic                                 i_abort,
    input  logic [N_LANES-1:0]                   i_lane_mask,
    input  logic [NB_CNT-1:0]                    i_burst_len,
    input  logic [NB_HOLD-1:0]                   i_sel_hold,
    input  logic                                 i_random,
    input  logic                                 i_test_mode,
    input  logic [1:0]                           i_valid_code,
    output logic [N_LANES-1:0]                   o_enable,
    output logic [N_LANES-1:0]                   o_random,
    output logic [N_LANES-1:0]                   o_test_mode,
    output logic [2*N_LANES-1:0]                 o_valid,
    output logic [N_PCS_WORDS_OUT*N_LANES-1:0]   o_data_sel,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [NB_CNT-1:0]                    o_cycle_cnt
);

    localparam int W        = N_PCS_WORDS_OUT;
    localparam int SEL_W    = N_PCS_WORDS_OUT * N_LANES;
    localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);
    localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N_LANES-1:0]   mask_q;
    logic [NB_CNT-1:0]    len_q;
    logic [NB_HOLD-1:0]   hold_q;
    logic [1:0]           code_q;
    logic [NB_HOLD-1:0]   hold_cnt;
    logic [NB_DRAIN-1:0]  drain_cnt;

    logic [NB_HOLD-1:0]   hold_eff;
    logic                 run_last;
    logic                 drain_last;
    logic                 rotate_now;
    logic [SEL_W-1:0]     sel_init;
    logic [2*N_LANES-1:0] valid_run;

    logic [N_LANES-1:0]   enable_nxt;
    logic [N_LANES-1:0]   random_nxt;
    logic [N_LANES-1:0]   test_nxt;
    logic [2*N_LANES-1:0] valid_nxt;
    logic [SEL_W-1:0]     sel_nxt;
    logic                 done_nxt;

    // Rotate every lane's one-hot select left by one, MSB wrapping into bit 0.
    function automatic logic [SEL_W-1:0] rotate_sel(input logic [SEL_W-1:0] s);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_LANES; k++) begin
            for (int b = 0; b < W; b++) begin
                r[k*W + b] = s[k*W + ((b + W - 1) % W)];
            end
        end
        return r;
    endfunction

    assign hold_eff   = (hold_q == '0) ? NB_HOLD'(1) : hold_q;
    assign run_last   = (o_cycle_cnt == len_q - NB_CNT'(1));
    assign drain_last = (drain_cnt == DRAIN_LAST);
    assign rotate_now = (state == S_RUN) && (hold_cnt == hold_eff - NB_HOLD'(1));

    always_comb begin
        sel_init  = '0;
        valid_run = '0;
        for (int k = 0; k < N_LANES; k++) begin
            sel_init[k*W + (k % W)] = i_lane_mask[k];
            valid_run[2*k +: 2]     = mask_q[k] ? code_q : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_lane_mask == '0 || i_burst_len == '0) ? S_DONE : S_ARM;
                end
            end
            S_ARM:   state_nxt = i_abort ? S_DRAIN : S_RUN;
            S_RUN: begin
                if (i_abort || run_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the state being entered.
    // ARM is only ever entered from IDLE, hence it reads the live config inputs.
    always_comb begin
        enable_nxt = '0;
        random_nxt = '0;
        test_nxt   = '0;
        valid_nxt  = '0;
        sel_nxt    = '0;
        done_nxt   = 1'b0;
        case (state_nxt)
            S_ARM: begin
                enable_nxt = i_lane_mask;
                random_nxt = i_lane_mask & {N_LANES{i_random}};
                test_nxt   = i_lane_mask & {N_LANES{i_test_mode}};
                sel_nxt    = sel_init;
            end
            S_RUN: begin
                enable_nxt = o_enable;
                random_nxt = o_random;
                test_nxt   = o_test_mode;
                valid_nxt  = valid_run;
                sel_nxt    = rotate_now ? rotate_sel(o_data_sel) : o_data_sel;
            end
            S_DRAIN: begin
                enable_nxt = o_enable;
                random_nxt = o_random;
                test_nxt   = o_test_mode;
                sel_nxt    = o_data_sel;
            end
            S_DONE:  done_nxt = 1'b1;
            default: done_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            mask_q      <= '0;
            len_q       <= '0;
            hold_q      <= '0;
            code_q      <= '0;
            hold_cnt    <= '0;
            drain_cnt   <= '0;
            o_cycle_cnt <= '0;
            o_enable    <= '0;
            o_random    <= '0;
            o_test_mode <= '0;
            o_valid     <= '0;
            o_data_sel  <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            if (state == S_IDLE && i_start) begin
                mask_q      <= i_lane_mask;
                len_q       <= i_burst_len;
                hold_q      <= i_sel_hold;
                code_q      <= i_valid_code;
                o_cycle_cnt <= '0;
            end else if (state == S_RUN) begin
                o_cycle_cnt <= o_cycle_cnt + NB_CNT'(1);
            end

            if (state == S_RUN) begin
                hold_cnt <= rotate_now ? '0 : hold_cnt + NB_HOLD'(1);
            end else begin
                hold_cnt <= '0;
            end

            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + NB_DRAIN'(1);
            end else begin
                drain_cnt <= '0;
            end

            o_enable    <= enable_nxt;
            o_random    <= random_nxt;
            o_test_mode <= test_nxt;
            o_valid     <= valid_nxt;
            o_data_sel  <= sel_nxt;
            o_done      <= done_nxt;
            o_busy      <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_pcs_gen_lane_scheduler.sv
// Directed bench for pcs_gen_lane_scheduler: reset, full/masked bursts, abort,
// zero-length start, start during RUN and reset mid-burst.
module tb_pcs_gen_lane_scheduler;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic        i_abort;
    logic [7:0]  i_lane_mask;
    logic [15:0] i_burst_len;
    logic [7:0]  i_sel_hold;
    logic        i_random;
    logic        i_test_mode;
    logic [1:0]  i_valid_code;
    logic [7:0]  o_enable;
    logic [7:0]  o_random;
    logic [7:0]  o_test_mode;
    logic [15:0] o_valid;
    logic [31:0] o_data_sel;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_cycle_cnt;

    int total;
    int bad;

    pcs_gen_lane_scheduler #(
        .N_LANES(8), .N_PCS_WORDS_OUT(4), .NB_CNT(16), .NB_HOLD(8), .DRAIN_CYCLES(4)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_lane_mask(i_lane_mask), .i_burst_len(i_burst_len), .i_sel_hold(i_sel_hold),
        .i_random(i_random), .i_test_mode(i_test_mode), .i_valid_code(i_valid_code),
        .o_enable(o_enable), .o_random(o_random), .o_test_mode(o_test_mode),
        .o_valid(o_valid), .o_data_sel(o_data_sel), .o_busy(o_busy), .o_done(o_done),
        .o_cycle_cnt(o_cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected select word: active lane k holds bit (k + steps) mod 4.
    function automatic logic [31:0] exp_sel(input logic [7:0] m, input int steps);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) r[k*4 + ((k + steps) % 4)] = 1'b1;
        end
        return r;
    endfunction

    task automatic start_burst(input logic [7:0] m, input logic [15:0] l, input logic [7:0] h,
                               input logic [1:0] c, input logic r, input logic t);
        i_lane_mask  = m;
        i_burst_len  = l;
        i_sel_hold   = h;
        i_valid_code = c;
        i_random     = r;
        i_test_mode  = t;
        i_start      = 1'b1;
        step();
        i_start      = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        total++;
        if ({o_enable, o_random, o_test_mode, o_valid} !== 40'h0) begin
            bad++;
            $display("[TB] FAIL reset_lanes: got %h want 0", {o_enable, o_random, o_test_mode, o_valid});
        end
        total++;
        if ({o_data_sel, o_busy, o_done, o_cycle_cnt} !== 50'h0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got sel=%h busy=%b done=%b cnt=%0d want 0",
                     o_data_sel, o_busy, o_done, o_cycle_cnt);
        end
        step();
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle_busy: got %b want 0", o_busy);
        end
    endtask

    task automatic test_full_burst();
        start_burst(8'hFF, 16'd10, 8'd2, 2'b01, 1'b1, 1'b0);
        total++;
        if (o_busy !== 1'b1 || o_enable !== 8'hFF || o_valid !== 16'h0) begin
            bad++;
            $display("[TB] FAIL full_arm: got busy=%b en=%h val=%h want 1 ff 0", o_busy, o_enable, o_valid);
        end
        total++;
        if (o_data_sel !== 32'h8421_8421 || o_random !== 8'hFF || o_test_mode !== 8'h00) begin
            bad++;
            $display("[TB] FAIL full_arm_sel: got sel=%h rnd=%h tm=%h want 84218421 ff 00",
                     o_data_sel, o_random, o_test_mode);
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            total++;
            if (o_valid !== 16'h5555 || o_cycle_cnt !== 16'(i - 1)) begin
                bad++;
                $display("[TB] FAIL full_run_valid c%0d: got val=%h cnt=%0d want 5555 %0d", i, o_valid, o_cycle_cnt, i - 1);
            end
            total++;
            if (o_data_sel !== exp_sel(8'hFF, (i - 1) / 2)) begin
                bad++;
                $display("[TB] FAIL full_run_sel c%0d: got %h want %h", i, o_data_sel, exp_sel(8'hFF, (i - 1) / 2));
            end
        end
        total++;
        if (o_data_sel[3:0] !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL full_lane0_last: got %b want 0001", o_data_sel[3:0]);
        end
        for (int d = 1; d <= 4; d++) begin
            step();
            total++;
            if (o_valid !== 16'h0 || o_enable !== 8'hFF || o_done !== 1'b0 || o_cycle_cnt !== 16'd10) begin
                bad++;
                $display("[TB] FAIL full_drain d%0d: got val=%h en=%h done=%b cnt=%0d want 0 ff 0 10",
                         d, o_valid, o_enable, o_done, o_cycle_cnt);
            end
        end
        step();
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_enable !== 8'h0 || o_data_sel !== 32'h0 || o_cycle_cnt !== 16'd10) begin
            bad++;
            $display("[TB] FAIL full_done: got done=%b busy=%b en=%h sel=%h cnt=%0d want 1 1 0 0 10",
                     o_done, o_busy, o_enable, o_data_sel, o_cycle_cnt);
        end
        step();
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_cycle_cnt !== 16'd10) begin
            bad++;
            $display("[TB] FAIL full_idle: got done=%b busy=%b cnt=%0d want 0 0 10", o_done, o_busy, o_cycle_cnt);
        end
    endtask

    task automatic test_masked_burst();
        start_burst(8'h05, 16'd3, 8'd1, 2'b10, 1'b1, 1'b1);
        total++;
        if (o_enable !== 8'h05 || o_random !== 8'h05 || o_test_mode !== 8'h05 || o_data_sel !== 32'h0000_0401) begin
            bad++;
            $display("[TB] FAIL mask_arm: got en=%h rnd=%h tm=%h sel=%h want 05 05 05 00000401",
                     o_enable, o_random, o_test_mode, o_data_sel);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (o_valid !== 16'h0022 || o_enable !== 8'h05 || o_data_sel !== exp_sel(8'h05, i - 1)) begin
                bad++;
                $display("[TB] FAIL mask_run c%0d: got val=%h en=%h sel=%h want 0022 05 %h",
                         i, o_valid, o_enable, o_data_sel, exp_sel(8'h05, i - 1));
            end
        end
        for (int d = 1; d <= 4; d++) begin
            step();
            total++;
            if (o_valid !== 16'h0 || o_data_sel !== exp_sel(8'h05, 2) || o_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL mask_drain d%0d: got val=%h sel=%h done=%b", d, o_valid, o_data_sel, o_done);
            end
        end
        step();
        total++;
        if (o_done !== 1'b1 || o_cycle_cnt !== 16'd3) begin
            bad++;
            $display("[TB] FAIL mask_done: got done=%b cnt=%0d want 1 3", o_done, o_cycle_cnt);
        end
        step();
    endtask

    task automatic test_abort();
        start_burst(8'hFF, 16'd100, 8'd3, 2'b11, 1'b0, 1'b0);
        step();
        step();
        step();
        i_abort = 1'b1;
        total++;
        if (o_valid !== 16'hFFFF || o_cycle_cnt !== 16'd2) begin
            bad++;
            $display("[TB] FAIL abort_run3: got val=%h cnt=%0d want ffff 2", o_valid, o_cycle_cnt);
        end
        for (int d = 1; d <= 4; d++) begin
            step();
            i_abort = 1'b0;
            total++;
            if (o_valid !== 16'h0 || o_cycle_cnt !== 16'd3 || o_enable !== 8'hFF ||
                o_data_sel !== 32'h8421_8421 || o_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort_drain d%0d: got val=%h cnt=%0d en=%h sel=%h done=%b",
                         d, o_valid, o_cycle_cnt, o_enable, o_data_sel, o_done);
            end
        end
        step();
        total++;
        if (o_done !== 1'b1 || o_cycle_cnt !== 16'd3) begin
            bad++;
            $display("[TB] FAIL abort_done: got done=%b cnt=%0d want 1 3", o_done, o_cycle_cnt);
        end
        step();
    endtask

    task automatic test_zero_len();
        start_burst(8'hFF, 16'd0, 8'd1, 2'b01, 1'b1, 1'b1);
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_enable !== 8'h0 || o_cycle_cnt !== 16'd0) begin
            bad++;
            $display("[TB] FAIL zero_done: got done=%b busy=%b en=%h cnt=%0d want 1 1 0 0",
                     o_done, o_busy, o_enable, o_cycle_cnt);
        end
        step();
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_enable !== 8'h0) begin
            bad++;
            $display("[TB] FAIL zero_idle: got done=%b busy=%b en=%h want 0 0 0", o_done, o_busy, o_enable);
        end
    endtask

    task automatic test_back_to_back();
        start_burst(8'h0F, 16'd5, 8'd1, 2'b01, 1'b0, 1'b0);
        step();
        step();
        i_start     = 1'b1;
        i_burst_len = 16'd2;
        i_lane_mask = 8'hF0;
        step();
        i_start = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            total++;
            if (o_valid !== 16'h0055 || o_enable !== 8'h0F || o_cycle_cnt !== 16'(i - 1)) begin
                bad++;
                $display("[TB] FAIL b2b_run c%0d: got val=%h en=%h cnt=%0d want 0055 0f %0d",
                         i, o_valid, o_enable, o_cycle_cnt, i - 1);
            end
            step();
        end
        for (int d = 2; d <= 4; d++) step();
        step();
        total++;
        if (o_done !== 1'b1 || o_cycle_cnt !== 16'd5) begin
            bad++;
            $display("[TB] FAIL b2b_done: got done=%b cnt=%0d want 1 5", o_done, o_cycle_cnt);
        end
        step();
        step();
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_not_queued: got busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        start_burst(8'hFF, 16'd20, 8'd2, 2'b01, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        total++;
        if ({o_enable, o_random, o_test_mode, o_valid, o_data_sel, o_busy, o_done, o_cycle_cnt} !== 90'h0) begin
            bad++;
            $display("[TB] FAIL midrst_clear: got en=%h val=%h sel=%h busy=%b cnt=%0d want all 0",
                     o_enable, o_valid, o_data_sel, o_busy, o_cycle_cnt);
        end
        start_burst(8'h03, 16'd2, 8'd1, 2'b11, 1'b0, 1'b0);
        step();
        total++;
        if (o_valid !== 16'h000F || o_data_sel !== 32'h0000_0021) begin
            bad++;
            $display("[TB] FAIL midrst_run1: got val=%h sel=%h want 000f 00000021", o_valid, o_data_sel);
        end
        step();
        total++;
        if (o_valid !== 16'h000F || o_data_sel !== 32'h0000_0042) begin
            bad++;
            $display("[TB] FAIL midrst_run2: got val=%h sel=%h want 000f 00000042", o_valid, o_data_sel);
        end
        for (int d = 1; d <= 4; d++) step();
        step();
        total++;
        if (o_done !== 1'b1 || o_cycle_cnt !== 16'd2) begin
            bad++;
            $display("[TB] FAIL midrst_done: got done=%b cnt=%0d want 1 2", o_done, o_cycle_cnt);
        end
    endtask

    initial begin
        clk          = 1'b0;
        i_rst        = 1'b0;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_lane_mask  = '0;
        i_burst_len  = '0;
        i_sel_hold   = '0;
        i_random     = 1'b0;
        i_test_mode  = 1'b0;
        i_valid_code = '0;
        total        = 0;
        bad          = 0;
        test_reset();
        test_full_burst();
        test_masked_burst();
        test_abort();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
